// File: rtl/dly_coarse_cal_ctrl_pkg.sv
// Shared types and constants for the coarse delay-line calibration controller.
package dly_coarse_cal_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DECIDE,
        ST_LOCK
    } state_t;

    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

    function automatic int code_max(input int num_stg);
        return 3 * num_stg;
    endfunction

endpackage

// File: rtl/dly_coarse_cal_ctrl_code2sel.sv
// Maps a total coarse code onto per-cell 2-bit selects; cells fill from cell 0 upwards.
module dly_coarse_cal_ctrl_code2sel #(
    parameter int NUM_STG = 4,
    parameter int CW      = 4
) (
    input  logic [CW-1:0]        i_code,
    output logic [2*NUM_STG-1:0] o_sel
);

    always_comb begin
        int rem;
        o_sel = '0;
        for (int k = 0; k < NUM_STG; k++) begin
            rem = int'(i_code) - 3 * k;
            if (rem >= 3) begin
                o_sel[2*k +: 2] = 2'd3;
            end else if (rem > 0) begin
                o_sel[2*k +: 2] = 2'(rem);
            end
        end
    end

endmodule

// File: rtl/dly_coarse_cal_ctrl.sv
// Coarse delay calibration: settle, majority-vote the PD late flag, step the code until dither or range end.
//  state  | meaning
//  IDLE   | waiting for start, code held
//  SETTLE | line settling after start or a code change
//  SAMPLE | accumulating PD late votes
//  DECIDE | one-cycle direction/lock/error decision
//  LOCK   | reversal count reached, code held until restart
module dly_coarse_cal_ctrl
    import dly_coarse_cal_ctrl_pkg::*;
#(
    parameter int NUM_STG    = 4,
    parameter int CW         = 4,
    parameter int CODE_INIT  = 6,
    parameter int SETTLE_CYC = 8,
    parameter int VOTE_N     = 16,
    parameter int LOCK_REV   = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_man_en,
    input  logic [CW-1:0]        i_man_code,
    input  logic                 i_pd_late,
    output logic [2*NUM_STG-1:0] o_sel,
    output logic [CW-1:0]        o_code,
    output logic                 o_busy,
    output logic                 o_lock,
    output logic                 o_err
);

    localparam int TMR_MAX = (SETTLE_CYC > VOTE_N) ? SETTLE_CYC : VOTE_N;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int VW      = $clog2(VOTE_N + 1);
    localparam int RW      = $clog2(LOCK_REV + 1);

    localparam logic [CW-1:0] C_MAX    = CW'(code_max(NUM_STG));
    localparam logic [CW-1:0] C_INIT   = CW'(CODE_INIT);
    localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] T_VOTE   = TW'(VOTE_N - 1);
    localparam logic [VW-1:0] V_HALF   = VW'(VOTE_N / 2);
    localparam logic [RW-1:0] R_LOCK   = RW'(LOCK_REV);

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_code, w_code_nxt;
    logic [2*NUM_STG-1:0]   r_sel, w_sel_nxt, w_sel_init;
    logic [TW-1:0]          r_tmr, w_tmr_nxt;
    logic [VW-1:0]          r_late, w_late_nxt;
    logic [RW-1:0]          r_rev, w_rev_nxt;
    logic                   r_last_dir, w_last_dir_nxt;
    logic                   r_dir_vld, w_dir_vld_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_lock, w_lock_nxt;
    logic                   r_err, w_err_nxt;
    logic                   w_dir, w_tie, w_rev_inc;

    dly_coarse_cal_ctrl_code2sel #(.NUM_STG(NUM_STG), .CW(CW)) u_sel_nxt (
        .i_code (w_code_nxt),
        .o_sel  (w_sel_nxt)
    );

    dly_coarse_cal_ctrl_code2sel #(.NUM_STG(NUM_STG), .CW(CW)) u_sel_init (
        .i_code (C_INIT),
        .o_sel  (w_sel_init)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = r_code;
        w_tmr_nxt      = r_tmr;
        w_late_nxt     = r_late;
        w_rev_nxt      = r_rev;
        w_last_dir_nxt = r_last_dir;
        w_dir_vld_nxt  = r_dir_vld;
        w_busy_nxt     = r_busy;
        w_lock_nxt     = r_lock;
        w_err_nxt      = r_err;
        w_dir          = DIR_INC;
        w_tie          = 1'b0;
        w_rev_inc      = 1'b0;

        if (i_man_en) begin
            w_state_nxt = ST_IDLE;
            w_code_nxt  = (i_man_code > C_MAX) ? C_MAX : i_man_code;
            w_busy_nxt  = 1'b0;
            w_lock_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOCK: begin
                    if (i_start) begin
                        w_state_nxt   = ST_SETTLE;
                        w_tmr_nxt     = T_SETTLE;
                        w_busy_nxt    = 1'b1;
                        w_lock_nxt    = 1'b0;
                        w_err_nxt     = 1'b0;
                        w_rev_nxt     = '0;
                        w_dir_vld_nxt = 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (r_tmr == '0) begin
                        w_state_nxt = ST_SAMPLE;
                        w_tmr_nxt   = T_VOTE;
                        w_late_nxt  = '0;
                    end else begin
                        w_tmr_nxt = r_tmr - TW'(1);
                    end
                end
                ST_SAMPLE: begin
                    w_late_nxt = r_late + VW'(i_pd_late);
                    if (r_tmr == '0) begin
                        w_state_nxt = ST_DECIDE;
                    end else begin
                        w_tmr_nxt = r_tmr - TW'(1);
                    end
                end
                ST_DECIDE: begin
                    w_tie     = (r_late == V_HALF);
                    w_dir     = (r_late > V_HALF) ? DIR_DEC : DIR_INC;
                    w_rev_inc = w_tie || (r_dir_vld && (w_dir != r_last_dir));
                    if (!w_tie) begin
                        w_last_dir_nxt = w_dir;
                        w_dir_vld_nxt  = 1'b1;
                    end
                    if (w_rev_inc && (r_rev != R_LOCK)) begin
                        w_rev_nxt = r_rev + RW'(1);
                    end
                    // Lock wins over saturation: a reversal at a range end is still a dither.
                    if (w_rev_nxt == R_LOCK) begin
                        w_state_nxt = ST_LOCK;
                        w_busy_nxt  = 1'b0;
                        w_lock_nxt  = 1'b1;
                    end else if (w_tie) begin
                        w_state_nxt = ST_SETTLE;
                        w_tmr_nxt   = T_SETTLE;
                    end else if (((w_dir == DIR_DEC) && (r_code == '0)) ||
                                 ((w_dir == DIR_INC) && (r_code == C_MAX))) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_tmr_nxt   = T_SETTLE;
                        w_code_nxt  = (w_dir == DIR_DEC) ? (r_code - CW'(1)) : (r_code + CW'(1));
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_code     <= C_INIT;
            r_sel      <= w_sel_init;
            r_tmr      <= '0;
            r_late     <= '0;
            r_rev      <= '0;
            r_last_dir <= DIR_INC;
            r_dir_vld  <= 1'b0;
            r_busy     <= 1'b0;
            r_lock     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_code     <= w_code_nxt;
            r_sel      <= w_sel_nxt;
            r_tmr      <= w_tmr_nxt;
            r_late     <= w_late_nxt;
            r_rev      <= w_rev_nxt;
            r_last_dir <= w_last_dir_nxt;
            r_dir_vld  <= w_dir_vld_nxt;
            r_busy     <= w_busy_nxt;
            r_lock     <= w_lock_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign o_sel  = r_sel;
    assign o_code = r_code;
    assign o_busy = r_busy;
    assign o_lock = r_lock;
    assign o_err  = r_err;

endmodule
